// File: rtl/snoop_bus_pkg.sv
// Shared types and constants for the MESI snoop-bus controller.
package snoop_bus_pkg;

  localparam int NUM_CPUS = 4;
  localparam int XLEN     = 32;
  localparam int SRC_W    = $clog2(NUM_CPUS);

  typedef enum logic [1:0] {
    Bus_Idle,
    Bus_Rd,
    Bus_RdX,
    Bus_Upgr
  } bus_tx_t;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] source;
    logic [XLEN-1:0]  addr;
    bus_tx_t          tx;
  } bus_msg_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BCAST,
    HOLD
  } snoop_bus_state_t;

endpackage

// File: rtl/snoop_bus_rr_arbiter.sv
// Combinational rotate-priority pick: first requester strictly after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          any_o,
  output logic [PW-1:0] winner_o
);

  always_comb begin : pick
    int idx;
    idx      = 0;
    any_o    = 1'b0;
    winner_o = '0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/snoop_bus.sv
// Snoop-bus controller: round-robin grant, one-cycle bus_msg broadcast, hold until all caches idle.
// Optional HOLD watchdog with timeout_err pulse when SNOOP_BUS_TIMEOUT_EN is defined.
module snoop_bus
  import snoop_bus_pkg::*;
#(
  parameter int N_PORTS        = NUM_CPUS,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic     [N_PORTS-1:0]           arbiter_req,
  input  logic     [N_PORTS-1:0]           arbiter_busy,
  input  logic     [N_PORTS-1:0][XLEN-1:0] bus_addr_in,
  input  bus_tx_t  [N_PORTS-1:0]           bus_tx_in,
  output logic     [N_PORTS-1:0]           arbiter_gnt,
  output bus_msg_t                         bus_msg
`ifdef SNOOP_BUS_TIMEOUT_EN
  , output logic                           timeout_err
`endif
);

  localparam int PW = $clog2(N_PORTS);

  snoop_bus_state_t   state_q;
  logic [PW-1:0]      owner_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [N_PORTS-1:0] gnt_q;
  bus_msg_t           msg_q;
  logic               any_req;
  logic [PW-1:0]      winner;

`ifdef SNOOP_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] hold_cnt_q;
  logic          terr_q;
  assign timeout_err = terr_q;
`endif

  rr_arbiter #(.N(N_PORTS), .PW(PW)) u_arb (
    .req_i    (arbiter_req),
    .ptr_i    (rr_ptr_q),
    .any_o    (any_req),
    .winner_o (winner)
  );

  assign arbiter_gnt = gnt_q;
  assign bus_msg     = msg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= PW'(N_PORTS - 1);
      gnt_q    <= '0;
      msg_q    <= '0;
`ifdef SNOOP_BUS_TIMEOUT_EN
      hold_cnt_q <= '0;
      terr_q     <= 1'b0;
`endif
    end else begin
`ifdef SNOOP_BUS_TIMEOUT_EN
      terr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            gnt_q   <= N_PORTS'(1) << winner;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          gnt_q <= '0;
          // Owner withdrew or has nothing to send: give up the slot without moving rr_ptr.
          if (!arbiter_req[owner_q] || bus_tx_in[owner_q] == Bus_Idle) begin
            state_q <= IDLE;
          end else begin
            msg_q.valid  <= 1'b1;
            msg_q.source <= SRC_W'(owner_q);
            msg_q.addr   <= bus_addr_in[owner_q];
            msg_q.tx     <= bus_tx_in[owner_q];
            state_q      <= BCAST;
          end
        end
        BCAST: begin
          msg_q.valid <= 1'b0;
          state_q     <= HOLD;
`ifdef SNOOP_BUS_TIMEOUT_EN
          hold_cnt_q  <= '0;
`endif
        end
        HOLD: begin
          if (arbiter_busy == '0) begin
            rr_ptr_q <= owner_q;
            state_q  <= IDLE;
`ifdef SNOOP_BUS_TIMEOUT_EN
          end else if (hold_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            rr_ptr_q <= owner_q;
            state_q  <= IDLE;
            terr_q   <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus.sv
// Directed scoreboard bench for snoop_bus: grants and broadcasts checked against queued expectations.
module tb_snoop_bus;
  import snoop_bus_pkg::*;

  localparam int N = NUM_CPUS;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req, busy, gnt;
  logic [N-1:0][XLEN-1:0] addr;
  bus_tx_t [N-1:0]        tx;
  bus_msg_t               msg;
`ifdef SNOOP_BUS_TIMEOUT_EN
  logic                   terr;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_gnt[$];
  bus_msg_t     exp_msg[$];

  always #5 clk = ~clk;

  snoop_bus #(.N_PORTS(N), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .arbiter_req  (req),
    .arbiter_busy (busy),
    .bus_addr_in  (addr),
    .bus_tx_in    (tx),
    .arbiter_gnt  (gnt),
    .bus_msg      (msg)
`ifdef SNOOP_BUS_TIMEOUT_EN
    , .timeout_err (terr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bus_msg_t mk(input int p);
    bus_msg_t m;
    m.valid  = 1'b1;
    m.source = SRC_W'(p);
    m.addr   = addr[p];
    m.tx     = tx[p];
    return m;
  endfunction

  task automatic expect_txn(input int p, input bit with_msg);
    logic [N-1:0] g;
    g = N'(1) << p;
    exp_gnt.push_back(g);
    if (with_msg) exp_msg.push_back(mk(p));
  endtask

  // Advance one clock, sample 1ns after the edge, and score any grant/broadcast seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gnt !== '0) begin
      if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'(0));
      else                     chk("gnt_sb", 64'(gnt), 64'(exp_gnt.pop_front()));
    end
    if (msg.valid !== 1'b0) begin
      if (exp_msg.size() == 0) chk("msg_unexpected", 64'(msg.valid), 64'(0));
      else                     chk("msg_sb", 64'(msg), 64'(exp_msg.pop_front()));
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    busy = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] eg;
    int p;
    rst  = 1'b1;
    req  = '0;
    busy = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = XLEN'(32'h100 + 32'h10 * i);
      tx[i]   = Bus_Rd;
    end

    // Reset state
    do_reset();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_msg", 64'(msg), 64'(0));

    // 1: single read from port 0
    addr[0] = XLEN'(32'h40);
    req = 4'b0001;
    expect_txn(0, 1'b1);
    tick();
    chk("t1_gnt_c1", 64'(gnt), 64'(4'b0001));
    chk("t1_valid_c1", 64'(msg.valid), 64'(0));
    tick();
    chk("t1_gnt_c2", 64'(gnt), 64'(0));
    chk("t1_valid_c2", 64'(msg.valid), 64'(1));
    req = '0;
    tick();
    chk("t1_valid_hold", 64'(msg.valid), 64'(0));
    chk("t1_addr_kept", 64'(msg.addr), 64'(32'h40));
    tick();
    chk("t1_idle_gnt", 64'(gnt), 64'(0));

    // 2: all four requesting, round-robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) addr[i] = XLEN'(32'h1000 + 32'h100 * i);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      p = t % N;
      eg = N'(1) << p;
      expect_txn(p, 1'b1);
      tick();
      chk("t2_gnt", 64'(gnt), 64'(eg));
      tick();
      chk("t2_gnt_pulse", 64'(gnt), 64'(0));
      chk("t2_valid", 64'(msg.valid), 64'(1));
      tick();
      chk("t2_valid_drop", 64'(msg.valid), 64'(0));
      if (t == 4) req = '0;
      tick();
      chk("t2_gap_gnt", 64'(gnt), 64'(0));
    end

    // 3: owner 2 RdX, busy[1] holds bus for 5 cycles while port 0 waits
    do_reset();
    tx[2]   = Bus_RdX;
    addr[2] = XLEN'(32'h200);
    addr[0] = XLEN'(32'h40);
    req = 4'b0100;
    expect_txn(2, 1'b1);
    tick();
    chk("t3_gnt", 64'(gnt), 64'(4'b0100));
    tick();
    chk("t3_valid", 64'(msg.valid), 64'(1));
    busy = 4'b0010;
    req  = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_gnt", 64'(gnt), 64'(0));
      chk("t3_hold_valid", 64'(msg.valid), 64'(0));
    end
    busy = '0;
    tick();
    chk("t3_release_gnt", 64'(gnt), 64'(0));
    expect_txn(0, 1'b1);
    tick();
    chk("t3_next_gnt", 64'(gnt), 64'(4'b0001));
    tick();
    req = '0;
    tick();
    tick();
    tx[2] = Bus_Rd;

    // 4: port 1 aborts (req drop, then Bus_Idle); rr_ptr stays so port 1 beats port 2
    do_reset();
    req = 4'b0010;
    expect_txn(1, 1'b0);
    tick();
    chk("t4_gnt_a", 64'(gnt), 64'(4'b0010));
    req = '0;
    tick();
    chk("t4_abort_valid_a", 64'(msg.valid), 64'(0));
    req   = 4'b0110;
    tx[1] = Bus_Idle;
    expect_txn(1, 1'b0);
    tick();
    chk("t4_gnt_b", 64'(gnt), 64'(4'b0010));
    tick();
    chk("t4_abort_valid_b", 64'(msg.valid), 64'(0));
    tx[1] = Bus_Rd;
    expect_txn(1, 1'b1);
    tick();
    chk("t4_gnt_c", 64'(gnt), 64'(4'b0010));
    tick();
    chk("t4_valid_c", 64'(msg.valid), 64'(1));
    req = '0;
    tick();
    tick();

    // 5: reset asserted while broadcasting
    do_reset();
    addr[2] = XLEN'(32'h300);
    req = 4'b0100;
    expect_txn(2, 1'b1);
    tick();
    tick();
    chk("t5_bcast_valid", 64'(msg.valid), 64'(1));
    rst = 1'b1;
    req = 4'b1100;
    tick();
    chk("t5_rst_valid", 64'(msg.valid), 64'(0));
    chk("t5_rst_gnt", 64'(gnt), 64'(0));
    chk("t5_rst_msg", 64'(msg), 64'(0));
    rst = 1'b0;
    expect_txn(2, 1'b1);
    tick();
    chk("t5_first_gnt", 64'(gnt), 64'(4'b0100));
    tick();
    req = '0;
    tick();
    tick();

`ifdef SNOOP_BUS_TIMEOUT_EN
    // 6: busy stuck high -> watchdog fires after 8 HOLD cycles
    do_reset();
    req = 4'b0001;
    expect_txn(0, 1'b1);
    tick();
    tick();
    busy = 4'b0001;
    req  = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t6_no_terr", 64'(terr), 64'(0));
    end
    tick();
    chk("t6_terr", 64'(terr), 64'(1));
    req = 4'b0010;
    expect_txn(1, 1'b1);
    tick();
    chk("t6_terr_pulse", 64'(terr), 64'(0));
    chk("t6_resume_gnt", 64'(gnt), 64'(4'b0010));
    tick();
    busy = '0;
    req  = '0;
    tick();
    tick();
`endif

    chk("sb_gnt_drained", 64'(exp_gnt.size()), 64'(0));
    chk("sb_msg_drained", 64'(exp_msg.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
